// File: rtl/vexriscv_mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the memory-side bridge.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the memory model.
interface vexriscv_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  i_cmd_valid;
  logic                  i_cmd_ready;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic                  i_rsp_valid;
  logic [DATA_WIDTH-1:0] i_rsp_data;
  logic                  i_rsp_err;

  logic                  d_cmd_valid;
  logic                  d_cmd_ready;
  logic                  d_cmd_write;
  logic [ADDR_WIDTH-1:0] d_cmd_addr;
  logic [DATA_WIDTH-1:0] d_cmd_wdata;
  logic [STRB_WIDTH-1:0] d_cmd_wstrb;
  logic                  d_rsp_valid;
  logic [DATA_WIDTH-1:0] d_rsp_data;
  logic                  d_rsp_err;

  logic                  m_cmd_valid;
  logic                  m_cmd_ready;
  logic                  m_cmd_write;
  logic [ADDR_WIDTH-1:0] m_cmd_addr;
  logic [DATA_WIDTH-1:0] m_cmd_wdata;
  logic [STRB_WIDTH-1:0] m_cmd_wstrb;
  logic                  m_rsp_valid;
  logic [DATA_WIDTH-1:0] m_rsp_data;
  logic                  m_rsp_err;

  modport slave (
    input  i_cmd_valid, i_cmd_addr,
    output i_cmd_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    input  d_cmd_valid, d_cmd_write, d_cmd_addr, d_cmd_wdata, d_cmd_wstrb,
    output d_cmd_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output m_cmd_valid, m_cmd_write, m_cmd_addr, m_cmd_wdata, m_cmd_wstrb,
    input  m_cmd_ready, m_rsp_valid, m_rsp_data, m_rsp_err
  );

  modport master (
    output i_cmd_valid, i_cmd_addr,
    input  i_cmd_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    output d_cmd_valid, d_cmd_write, d_cmd_addr, d_cmd_wdata, d_cmd_wstrb,
    input  d_cmd_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  m_cmd_valid, m_cmd_write, m_cmd_addr, m_cmd_wdata, m_cmd_wstrb,
    output m_cmd_ready, m_rsp_valid, m_rsp_data, m_rsp_err
  );
endinterface

// File: rtl/vexriscv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// one transaction in flight, responses routed to the issuing requester, with a response watchdog.
module vexriscv_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic                   ACLK,
  input logic                   ARESET,
  vexriscv_mem_arbiter_if.slave bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t               state;
  owner_t               owner;
  owner_t               last_grant;
  logic [CNT_WIDTH-1:0] tmo_cnt;

  logic                  grant_i_c;
  logic                  grant_d_c;
  logic                  tmo_hit_c;
  logic                  rsp_err_c;
  logic [DATA_WIDTH-1:0] rsp_data_c;

  // Tie goes to whoever was not served last; a real response beats a simultaneous timeout.
  always_comb begin
    grant_i_c  = bus.i_cmd_valid && (!bus.d_cmd_valid || (last_grant == OWN_DATA));
    grant_d_c  = bus.d_cmd_valid && !grant_i_c;
    tmo_hit_c  = (TIMEOUT != 0) && (tmo_cnt == CNT_WIDTH'(TIMEOUT - 1));
    rsp_err_c  = bus.m_rsp_valid ? bus.m_rsp_err : 1'b1;
    rsp_data_c = (bus.m_rsp_valid && !bus.m_cmd_write) ? bus.m_rsp_data : '0;
  end

  assign bus.i_cmd_ready = (state == IDLE) && grant_i_c;
  assign bus.d_cmd_ready = (state == IDLE) && grant_d_c;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state           <= IDLE;
      owner           <= OWN_INST;
      last_grant      <= OWN_DATA;
      tmo_cnt         <= '0;
      bus.i_rsp_valid <= 1'b0;
      bus.i_rsp_data  <= '0;
      bus.i_rsp_err   <= 1'b0;
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_data  <= '0;
      bus.d_rsp_err   <= 1'b0;
      bus.m_cmd_valid <= 1'b0;
      bus.m_cmd_write <= 1'b0;
      bus.m_cmd_addr  <= '0;
      bus.m_cmd_wdata <= '0;
      bus.m_cmd_wstrb <= '0;
    end else begin
      // Response outputs are single-cycle pulses and read as zero otherwise.
      bus.i_rsp_valid <= 1'b0;
      bus.i_rsp_data  <= '0;
      bus.i_rsp_err   <= 1'b0;
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_data  <= '0;
      bus.d_rsp_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_i_c) begin
            bus.m_cmd_valid <= 1'b1;
            bus.m_cmd_write <= 1'b0;
            bus.m_cmd_addr  <= ADDR_WIDTH'(bus.i_cmd_addr);
            bus.m_cmd_wdata <= '0;
            bus.m_cmd_wstrb <= '0;
            owner           <= OWN_INST;
            last_grant      <= OWN_INST;
            state           <= CMD;
          end else if (grant_d_c) begin
            bus.m_cmd_valid <= 1'b1;
            bus.m_cmd_write <= bus.d_cmd_write;
            bus.m_cmd_addr  <= ADDR_WIDTH'(bus.d_cmd_addr);
            bus.m_cmd_wdata <= DATA_WIDTH'(bus.d_cmd_wdata);
            bus.m_cmd_wstrb <= bus.d_cmd_write ? STRB_WIDTH'(bus.d_cmd_wstrb) : '0;
            owner           <= OWN_DATA;
            last_grant      <= OWN_DATA;
            state           <= CMD;
          end
        end
        CMD: begin
          if (bus.m_cmd_ready) begin
            bus.m_cmd_valid <= 1'b0;
            tmo_cnt         <= '0;
            state           <= RSP;
          end
        end
        RSP: begin
          if (bus.m_rsp_valid || tmo_hit_c) begin
            if (owner == OWN_INST) begin
              bus.i_rsp_valid <= 1'b1;
              bus.i_rsp_data  <= rsp_data_c;
              bus.i_rsp_err   <= rsp_err_c;
            end else begin
              bus.d_rsp_valid <= 1'b1;
              bus.d_rsp_data  <= rsp_data_c;
              bus.d_rsp_err   <= rsp_err_c;
            end
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vexriscv_mem_arbiter.sv
// Scoreboard bench for vexriscv_mem_arbiter: directed requests, a memory responder model,
// and a negedge monitor comparing every memory command and requester response against queued expectations.
module tb_vexriscv_mem_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } mem_t;

  logic clk;
  logic rst;

  vexriscv_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vexriscv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .ACLK  (clk),
    .ARESET(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cyc   = 0;

  logic [31:0] i_q[$];
  cmd_t        d_q[$];
  cmd_t        cmd_q[$];
  rsp_t        rsp_q[$];
  mem_t        mem_q[$];

  int unsigned ready_hold = 0;
  bit          drop_rsp   = 1'b0;
  int          stray_req  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.wstrb = wstrb;
    return c;
  endfunction

  // Queue the command the memory side must see, what memory answers, and what the owner must get back.
  task automatic exp_txn(input bit is_data, input cmd_t c, input logic [31:0] mdata, input logic merr,
                         input logic [31:0] rdata, input logic rerr, input int lat);
    rsp_t r;
    mem_t m;
    cmd_q.push_back(c);
    m.data = mdata; m.err = merr;
    mem_q.push_back(m);
    r.is_data = is_data; r.data = rdata; r.err = rerr; r.lat = lat;
    rsp_q.push_back(r);
  endtask

  // Requester drivers and memory responder, all driven 1 time unit after the rising edge.
  int unsigned wait_cnt = 0;
  int          stray_done = 0;
  initial begin
    bit   i_fire, d_fire, hs;
    mem_t m;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_addr = '0;
    bus.d_cmd_valid = 1'b0; bus.d_cmd_write = 1'b0; bus.d_cmd_addr = '0;
    bus.d_cmd_wdata = '0;   bus.d_cmd_wstrb = '0;
    bus.m_cmd_ready = 1'b1; bus.m_rsp_valid = 1'b0; bus.m_rsp_data = '0; bus.m_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      i_fire = bus.i_cmd_valid && bus.i_cmd_ready && !rst;
      d_fire = bus.d_cmd_valid && bus.d_cmd_ready && !rst;
      hs     = bus.m_cmd_valid && bus.m_cmd_ready && !rst;
      @(posedge clk);
      #1;
      if (i_fire && i_q.size() != 0) void'(i_q.pop_front());
      if (d_fire && d_q.size() != 0) void'(d_q.pop_front());
      bus.i_cmd_valid = (i_q.size() != 0);
      bus.i_cmd_addr  = (i_q.size() != 0) ? i_q[0] : 32'h0;
      bus.d_cmd_valid = (d_q.size() != 0);
      if (d_q.size() != 0) begin
        bus.d_cmd_write = d_q[0].wr;    bus.d_cmd_addr  = d_q[0].addr;
        bus.d_cmd_wdata = d_q[0].wdata; bus.d_cmd_wstrb = d_q[0].wstrb;
      end else begin
        bus.d_cmd_write = 1'b0; bus.d_cmd_addr = '0; bus.d_cmd_wdata = '0; bus.d_cmd_wstrb = '0;
      end
      bus.m_rsp_valid = 1'b0; bus.m_rsp_data = '0; bus.m_rsp_err = 1'b0;
      if (hs && !drop_rsp && mem_q.size() != 0) begin
        m = mem_q.pop_front();
        bus.m_rsp_valid = 1'b1; bus.m_rsp_data = m.data; bus.m_rsp_err = m.err;
      end else if (stray_req != stray_done) begin
        stray_done      = stray_req;
        bus.m_rsp_valid = 1'b1; bus.m_rsp_data = 32'hBAD0BAD0; bus.m_rsp_err = 1'b0;
      end
      if (!bus.m_cmd_valid) begin
        wait_cnt        = ready_hold;
        bus.m_cmd_ready = (ready_hold == 0);
      end else if (wait_cnt != 0) begin
        wait_cnt--;
        bus.m_cmd_ready = 1'b0;
      end else begin
        bus.m_cmd_ready = 1'b1;
      end
    end
  end

  // Monitor: memory command held against the queue head every cycle; responses popped and compared.
  always @(negedge clk) begin
    rsp_t        e;
    logic [67:0] exp_v;
    if (bus.m_cmd_valid) begin
      if (cmd_q.size() == 0) begin
        check("m_cmd_unexpected", 128'(bus.m_cmd_valid), 128'(0));
      end else begin
        check("m_cmd", 128'({bus.m_cmd_write, bus.m_cmd_addr, bus.m_cmd_wdata, bus.m_cmd_wstrb}),
              128'({cmd_q[0].wr, cmd_q[0].addr, cmd_q[0].wdata, cmd_q[0].wstrb}));
        if (bus.m_cmd_ready) begin
          void'(cmd_q.pop_front());
          hs_cyc = cyc + 1;
        end
      end
    end
    if (bus.i_rsp_valid || bus.d_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 128'({bus.i_rsp_valid, bus.d_rsp_valid}), 128'(0));
      end else begin
        e = rsp_q.pop_front();
        exp_v = e.is_data ? {1'b0, 32'h0, 1'b0, 1'b1, e.data, e.err}
                          : {1'b1, e.data, e.err, 1'b0, 32'h0, 1'b0};
        check("rsp", 128'({bus.i_rsp_valid, bus.i_rsp_data, bus.i_rsp_err,
                           bus.d_rsp_valid, bus.d_rsp_data, bus.d_rsp_err}), 128'(exp_v));
        check("rsp_latency", 128'(cyc - hs_cyc), 128'(e.lat));
      end
    end
  end

  task automatic check_zero(input string name);
    check({name, "_rsp"}, 128'({bus.i_rsp_valid, bus.i_rsp_data, bus.i_rsp_err,
                                bus.d_rsp_valid, bus.d_rsp_data, bus.d_rsp_err}), 128'(0));
    check({name, "_cmd"}, 128'({bus.i_cmd_ready, bus.d_cmd_ready, bus.m_cmd_valid, bus.m_cmd_write,
                                bus.m_cmd_addr, bus.m_cmd_wdata, bus.m_cmd_wstrb}), 128'(0));
  endtask

  task automatic wait_done(input string name, input int max);
    int k = 0;
    bit busy;
    busy = (i_q.size() + d_q.size() + cmd_q.size() + rsp_q.size()) != 0;
    while (busy && k < max) begin
      @(negedge clk);
      k++;
      busy = (i_q.size() + d_q.size() + cmd_q.size() + rsp_q.size()) != 0;
    end
    check({name, "_done"}, 128'(busy), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // Single instruction fetch, zero-wait memory.
    i_q.push_back(32'h100);
    exp_txn(1'b0, mk_cmd(1'b0, 32'h100, 32'h0, 4'h0), 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1);
    @(negedge clk);
    check("t1_i_ready", 128'(bus.i_cmd_ready), 128'(1));
    @(negedge clk);
    check("t1_m_cmd", 128'({bus.m_cmd_valid, bus.m_cmd_addr}), 128'({1'b1, 32'h100}));
    wait_done("t1", 50);

    // Both requesters valid continuously: fresh reset so INST wins the first tie.
    pulse_reset();
    @(negedge clk);
    i_q.push_back(32'h400); i_q.push_back(32'h404);
    d_q.push_back(mk_cmd(1'b0, 32'h800, 32'h0, 4'hF));
    d_q.push_back(mk_cmd(1'b0, 32'h804, 32'h0, 4'hF));
    exp_txn(1'b0, mk_cmd(1'b0, 32'h400, 32'h0, 4'h0), 32'h11111111, 1'b0, 32'h11111111, 1'b0, 1);
    exp_txn(1'b1, mk_cmd(1'b0, 32'h800, 32'h0, 4'h0), 32'h22222222, 1'b0, 32'h22222222, 1'b0, 1);
    exp_txn(1'b0, mk_cmd(1'b0, 32'h404, 32'h0, 4'h0), 32'h33333333, 1'b0, 32'h33333333, 1'b0, 1);
    exp_txn(1'b1, mk_cmd(1'b0, 32'h804, 32'h0, 4'h0), 32'h44444444, 1'b0, 32'h44444444, 1'b0, 1);
    wait_done("t2", 100);

    // Data write with memory stalling the command for 5 cycles; write response data reads as 0.
    ready_hold = 5;
    @(negedge clk);
    @(negedge clk);
    d_q.push_back(mk_cmd(1'b1, 32'h200, 32'h12345678, 4'hF));
    exp_txn(1'b1, mk_cmd(1'b1, 32'h200, 32'h12345678, 4'hF), 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1);
    wait_done("t3", 60);
    ready_hold = 0;
    @(negedge clk);

    // Memory never answers: error after TMO cycles, then a late response is dropped.
    drop_rsp = 1'b1;
    d_q.push_back(mk_cmd(1'b0, 32'h300, 32'h0, 4'h0));
    cmd_q.push_back(mk_cmd(1'b0, 32'h300, 32'h0, 4'h0));
    begin
      rsp_t r;
      r.is_data = 1'b1; r.data = 32'h0; r.err = 1'b1; r.lat = TMO;
      rsp_q.push_back(r);
    end
    wait_done("t4", 100);
    stray_req++;
    repeat (4) begin
      @(negedge clk);
      check("t4_stray_dropped", 128'({bus.i_rsp_valid, bus.d_rsp_valid}), 128'(0));
    end
    drop_rsp = 1'b0;

    // Reset while waiting in RSP abandons the fetch; a following data read completes.
    drop_rsp = 1'b1;
    i_q.push_back(32'h500);
    cmd_q.push_back(mk_cmd(1'b0, 32'h500, 32'h0, 4'h0));
    k = 0;
    while (cmd_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_cmd_issued", 128'(cmd_q.size()), 128'(0));
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("t5_after_reset");
    drop_rsp = 1'b0;
    d_q.push_back(mk_cmd(1'b0, 32'h600, 32'h0, 4'h0));
    exp_txn(1'b1, mk_cmd(1'b0, 32'h600, 32'h0, 4'h0), 32'h66666666, 1'b0, 32'h66666666, 1'b0, 1);
    wait_done("t5", 60);

    // Bus error on a data read, then a normal fetch proves the FSM is back in IDLE.
    d_q.push_back(mk_cmd(1'b0, 32'h700, 32'h0, 4'h0));
    exp_txn(1'b1, mk_cmd(1'b0, 32'h700, 32'h0, 4'h0), 32'h0BADF00D, 1'b1, 32'h0BADF00D, 1'b1, 1);
    wait_done("t6a", 60);
    i_q.push_back(32'h104);
    exp_txn(1'b0, mk_cmd(1'b0, 32'h104, 32'h0, 4'h0), 32'h13579BDF, 1'b0, 32'h13579BDF, 1'b0, 1);
    wait_done("t6b", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule
